// File: rtl/led_pkg.sv
// Shared widths, FSM encoding and the phase-to-triangle fold for the LED breathing PWM.
package led_pkg;

  localparam int PWM_BITS   = 8;
  localparam int PHASE_BITS = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } led_state_t;

  // Upper half of the phase circle runs the 8-bit ramp back down.
  function automatic logic [PWM_BITS-1:0] tri_fold(input logic [PHASE_BITS-1:0] phase);
    return phase[PHASE_BITS-1] ? ~phase[PWM_BITS-1:0] : phase[PWM_BITS-1:0];
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: period-latched duty, optional gamma curve, registered compare output.
// Build option: define LED_GAMMA_EN to square the duty level before latching.
module led_pwm_channel
  import led_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PWM_BITS-1:0] level,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                active,
  output logic                led
);

  logic [PWM_BITS-1:0] duty_reg;
  logic [PWM_BITS-1:0] duty_next;
  logic                led_reg;

`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq;
  assign level_sq  = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
  assign duty_next = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty_next = level;
`endif

  // Duty only changes at a period boundary, so a period is never cut short or stretched.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_reg <= '0;
      led_reg  <= 1'b0;
    end else begin
      if (load) begin
        duty_reg <= duty_next;
      end
      led_reg <= active && (pwm_cnt < duty_reg);
    end
  end

  assign led = led_reg;

endmodule

// File: rtl/led_breath_pwm.sv
// Three phase-offset breathing LEDs from one shared triangle-phase generator.
// Build option: LED_GAMMA_EN selects a squared (gamma) duty curve in each channel.
module led_breath_pwm
  import led_pkg::*;
#(
  parameter int STEP_PERIODS = 16,
  parameter int CH_OFFSET    = 170
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [2:0] led,
  output logic       pwm_wrap,
  output logic       busy
);

  localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);

  led_state_t            state_reg;
  led_state_t            state_next;
  logic [PWM_BITS-1:0]   pwm_cnt_reg;
  logic [STEP_W-1:0]     step_cnt_reg;
  logic [PHASE_BITS-1:0] phase_reg;
  logic                  at_wrap;
  logic                  load;
  logic                  active;

  assign at_wrap = (pwm_cnt_reg == {PWM_BITS{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // DRAIN only leaves for IDLE on the last count, so the final period always completes.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (en) state_next = ST_RUN;
      ST_RUN:   if (!en) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (en) begin
          state_next = ST_RUN;
        end else if (at_wrap) begin
          state_next = ST_IDLE;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg != ST_IDLE);
    active   = busy;
    pwm_wrap = busy && at_wrap;
    load     = pwm_wrap || ((state_reg == ST_IDLE) && en);
  end

  // phase and step_cnt survive IDLE so a restart resumes the breath where it stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_reg  <= '0;
      step_cnt_reg <= '0;
      phase_reg    <= '0;
    end else if (busy) begin
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      if (at_wrap) begin
        if (step_cnt_reg == STEP_LAST) begin
          step_cnt_reg <= '0;
          phase_reg    <= phase_reg + 1'b1;
        end else begin
          step_cnt_reg <= step_cnt_reg + 1'b1;
        end
      end
    end else begin
      pwm_cnt_reg <= '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      localparam logic [PHASE_BITS-1:0] CH_PHASE_OFS =
        PHASE_BITS'((gi * CH_OFFSET) % (1 << PHASE_BITS));
      logic [PHASE_BITS-1:0] ch_phase;
      logic [PWM_BITS-1:0]   ch_level;

      assign ch_phase = phase_reg + CH_PHASE_OFS;
      assign ch_level = tri_fold(ch_phase);

      led_pwm_channel u_ch (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .level   (ch_level),
        .pwm_cnt (pwm_cnt_reg),
        .active  (active),
        .led     (led[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_led_breath_pwm.sv
// Randomized session bench for led_breath_pwm: per-period LED high counts against a phase model.
module tb_led_breath_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] led;
  logic       pwm_wrap;
  logic       busy;

  always #5 clk = ~clk;

  led_breath_pwm #(.STEP_PERIODS(1), .CH_OFFSET(170)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .led      (led),
    .pwm_wrap (pwm_wrap),
    .busy     (busy)
  );

  typedef struct {
    int phase;
    int c[3];
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_phase  = 0;
  int   flush_req  = 0;
  int   flush_seen = 0;
  int   idle_bad   = 0;
  int   cnt[3];
  int   gap = 0;
  bit   last_valid = 1'b0;

  function automatic int tri_ref(int p);
    int q;
    q = ((p % 512) + 512) % 512;
    return (q < 256) ? q : 511 - q;
  endfunction

  function automatic int duty_ref(int ph, int k);
    int t;
    t = tri_ref(ph + k * 170);
`ifdef LED_GAMMA_EN
    return (t * t) / 256;
`else
    return t;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_period(input int ph);
    exp_t e;
    e.phase = ph;
    for (int k = 0; k < 3; k++) e.c[k] = duty_ref(ph, k);
    expq.push_back(e);
  endtask

  // Period 0 uses the phase latched on start; each later period uses the phase
  // that was current during the period before it.
  task automatic run_session(input int n, input bit glitch, input int d);
    int ph0;
    int g1;
    int g2;
    ph0 = m_phase;
    for (int i = 0; i < n; i++) push_period((i == 0) ? ph0 : ph0 + i - 1);
    en = 1'b1;
    tick(1);
    check("busy_on_start", busy, 1);
    for (int i = 0; i < n - 1; i++) begin
      if (glitch && i == 0) begin
        g1 = $urandom_range(120, 1);
        g2 = $urandom_range(250, 130);
        tick(g1);
        en = 1'b0;
        tick(g2 - g1);
        check("busy_during_drain_glitch", busy, 1);
        en = 1'b1;
        tick(256 - g2);
      end else begin
        tick(256);
      end
    end
    tick(d);
    en = 1'b0;
    tick(255 - d);
    check("drain_busy_at_255", busy, 1);
    check("drain_wrap_at_255", pwm_wrap, 1);
    tick(1);
    check("busy_after_drain", busy, 0);
    check("led_after_drain", led, 0);
    m_phase += n;
  endtask

  task automatic reset_mid(input int r);
    push_period(m_phase);
    en = 1'b1;
    tick(1);
    tick(256);
    tick(r);
    rst = 1'b1;
    tick(1);
    check("rst_mid_led", led, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_wrap", pwm_wrap, 0);
    rst = 1'b0;
    en  = 1'b0;
    flush_req++;
    m_phase = 0;
  endtask

  // Every LED high for a period lands on counts 1..duty of that same period,
  // so totals are closed out on the wrap cycle.
  initial begin
    exp_t e;
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    forever begin
      @(negedge clk);
      if (flush_req != flush_seen) begin
        flush_seen = flush_req;
        for (int k = 0; k < 3; k++) cnt[k] = 0;
        expq.delete();
        last_valid = 1'b0;
      end
      if (!busy && led != 3'b000) idle_bad++;
      for (int k = 0; k < 3; k++) cnt[k] += int'(led[k]);
      gap++;
      if (pwm_wrap) begin
        if (last_valid) check("wrap_gap", gap, 256);
        last_valid = 1'b1;
        gap = 0;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wrap actual=wrap required=no_wrap");
        end else begin
          e = expq.pop_front();
          $display("period phase=%0d led_high=%0d/%0d/%0d expect=%0d/%0d/%0d",
                   e.phase, cnt[0], cnt[1], cnt[2], e.c[0], e.c[1], e.c[2]);
          check("led0_high_count", cnt[0], e.c[0]);
          check("led1_high_count", cnt[1], e.c[1]);
          check("led2_high_count", cnt[2], e.c[2]);
        end
        for (int k = 0; k < 3; k++) cnt[k] = 0;
      end
      if (!busy) last_valid = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    tick(3);
    check("reset_led", led, 0);
    check("reset_busy", busy, 0);
    check("reset_wrap", pwm_wrap, 0);
    rst = 1'b0;
    tick(2);
    check("idle_busy", busy, 0);

    run_session(2, 1'b0, 100);
    tick(5);
    run_session(3, 1'b1, 100);
    tick(7);
    reset_mid(50);
    tick(3);
    run_session(2, 1'b0, 200);

    for (int ep = 0; ep < 10; ep++) begin
      if ($urandom_range(3, 0) == 0) begin
        reset_mid($urandom_range(240, 10));
      end else begin
        run_session($urandom_range(3, 1), 1'($urandom_range(1, 0)), $urandom_range(254, 1));
      end
      tick($urandom_range(20, 1));
    end

    run_session(135, 1'b1, $urandom_range(254, 1));
    tick(5);
    check("idle_led_zero", idle_bad, 0);
    check("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
